// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, access-size codes and byte-lane mask helper
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane, input int nb);
    int m;
    m = ((1 << (1 << size)) - 1) << lane;
    return 8'(m & ((1 << nb) - 1));
  endfunction
endpackage

// File: rtl/byte_lane_steer.sv
// byte_lane_steer: byte-lane enables and lane-aligned, size-masked write data for a store
module byte_lane_steer import mem_ctrl_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [LB-1:0]     lane,
  input  logic [DATA_W-1:0] store_data,
  output logic [NB-1:0]     byteenable,
  output logic [DATA_W-1:0] writedata
);
  logic [NB-1:0] size_mask;
  logic [DATA_W-1:0] bit_mask;
  assign size_mask = NB'(lane_mask(size, 3'd0, NB));
  assign byteenable = NB'(lane_mask(size, 3'(lane), NB));
  for (genvar i = 0; i < NB; i++) begin : g_mask
    assign bit_mask[8*i +: 8] = {8{size_mask[i]}};
  end
  assign writedata = (store_data & bit_mask) << {lane, 3'b000};
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request load/store bus controller with lane steering, misalign detection and waitrequest timeout
module mem_access_ctrl import mem_ctrl_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255,
  localparam int NB = DATA_W / 8,
  localparam int LB = $clog2(NB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [NB-1:0]     byteenable,
  output logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned,
  output logic              bus_error
);
  localparam int CW = $clog2(TIMEOUT + 2);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic read_q, read_d, write_q, write_d, mis_q, mis_d, err_q, err_d;
  logic [NB-1:0] be_q, be_d, steer_be;
  logic [DATA_W-1:0] wd_q, wd_d, ld_q, ld_d, steer_wd;
  logic [LB-1:0] lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bad, timed_out;
  byte_lane_steer #(.DATA_W(DATA_W)) u_steer (
    .size(size),
    .lane(addr[LB-1:0]),
    .store_data(store_data),
    .byteenable(steer_be),
    .writedata(steer_wd)
  );
  assign bad = (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00) ||
               (size == SZ_DWORD && (DATA_W == 32 || addr[2:0] != 3'b000));
  // abort on the TIMEOUT-th stalled cycle, so a strobe is never held stalled longer than TIMEOUT cycles
  assign timed_out = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    address_d = address_q;
    read_d = read_q;
    write_d = write_q;
    be_d = be_q;
    wd_d = wd_q;
    ld_d = ld_q;
    mis_d = mis_q;
    err_d = err_q;
    lane_d = lane_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      mis_d = bad;
      err_d = 1'b0;
      state_d = bad ? DONE : ACCESS;
      if (!bad) begin
        address_d = {addr[ADDR_W-1:LB], {LB{1'b0}}};
        read_d = !is_store;
        write_d = is_store;
        be_d = is_store ? steer_be : '1;
        wd_d = is_store ? steer_wd : '0;
        lane_d = addr[LB-1:0];
        cnt_d = '0;
      end
    end else if (state_q == ACCESS) begin
      if (!waitrequest || timed_out) begin
        read_d = 1'b0;
        write_d = 1'b0;
        err_d = waitrequest;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ld_d = (!waitrequest && read_q) ? readdata >> {lane_q, 3'b000} : ld_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      address_q <= '0;
      read_q <= 1'b0;
      write_q <= 1'b0;
      be_q <= '1;
      wd_q <= '0;
      ld_q <= '0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      lane_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      address_q <= address_d;
      read_q <= read_d;
      write_q <= write_d;
      be_q <= be_d;
      wd_q <= wd_d;
      ld_q <= ld_d;
      mis_q <= mis_d;
      err_q <= err_d;
      lane_q <= lane_d;
      cnt_q <= cnt_d;
    end
  end
  assign address = address_q;
  assign read = read_q;
  assign write = write_q;
  assign byteenable = be_q;
  assign writedata = wd_q;
  assign load_data = ld_q;
  assign misaligned = mis_q;
  assign bus_error = err_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
